// File: rtl/bcd_scan_display.sv
// Time-multiplexed seven-segment driver for a chain of BCD digits.
// A snapshot of all digits is taken once per frame, then each digit is shown for
// PRESCALE cycles with optional leading-zero blanking. an/seg are combinational
// decodes of the registered scan state, so they carry no added latency.
module bcd_scan_display #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  freeze,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);
    localparam logic [IdxW-1:0] IdxMax = IdxW'(DIGITS - 1);

    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic                frame_done_q, frame_done_d;

    logic                dwell_end;
    logic                frame_end;
    logic [3:0]          nib;
    logic                sel_lz;
    logic                lz_run;
    logic                blank;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40; // invalid code shows a dash
        endcase
        return s;
    endfunction

    // Next-state: dwell counter, scan index and frame-boundary snapshot.
    always_comb begin
        dwell_end = (cnt_q == CntMax);
        frame_end = dwell_end && (idx_q == IdxMax);
        cnt_d     = dwell_end ? '0 : cnt_q + CntW'(1);
        idx_d     = idx_q;
        if (dwell_end) begin
            idx_d = (idx_q == IdxMax) ? '0 : idx_q + IdxW'(1);
        end
        // freeze only matters on the boundary edge
        shadow_d     = (frame_end && !freeze) ? bcd_in : shadow_q;
        frame_done_d = frame_end;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Digit select, nibble mux and leading-zero detection, scanning from the MSD down.
    always_comb begin
        an     = '0;
        nib    = 4'd0;
        sel_lz = 1'b0;
        lz_run = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            // lz_run stays set while this digit and all above it are zero
            lz_run = lz_run & (shadow_q[4*i +: 4] == 4'd0);
            if (idx_q == IdxW'(i)) begin
                an[i]  = 1'b1;
                nib    = shadow_q[4*i +: 4];
                sel_lz = lz_run;
            end
        end
        blank = (BLANK_LZ != 0) && sel_lz && (idx_q != '0);
        seg   = blank ? 7'h00 : bcd_to_seg(nib);
    end

    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomised and directed bench for bcd_scan_display. Four instances cover the
// default configuration, BLANK_LZ=0, the DIGITS=1/PRESCALE=1 counter hookup and
// an odd 3-digit/2-cycle configuration, all checked against a time-based model.
module tb_bcd_scan_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bcd16;
    logic [11:0] bcd12;
    logic        frz;
    logic [3:0]  cnt10;

    logic [6:0]  seg_a, seg_b, seg_c, seg_d;
    logic [3:0]  an_a, an_b;
    logic [0:0]  an_c;
    logic [2:0]  an_d;
    logic        fd_a, fd_b, fd_c, fd_d;

    int n_checks = 0;
    int n_errors = 0;

    // Model: t counts edges since the last reset edge; each snapshot is the input
    // seen at the edge that ends a frame.
    int          t;
    logic [31:0] s_ab, s_c, s_d;

    always #5 clk = ~clk;

    bcd_scan_display #(.DIGITS(4), .PRESCALE(4), .BLANK_LZ(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bcd_in(bcd16), .freeze(frz),
        .seg(seg_a), .an(an_a), .frame_done(fd_a)
    );

    bcd_scan_display #(.DIGITS(4), .PRESCALE(4), .BLANK_LZ(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bcd_in(bcd16), .freeze(frz),
        .seg(seg_b), .an(an_b), .frame_done(fd_b)
    );

    bcd_scan_display #(.DIGITS(1), .PRESCALE(1), .BLANK_LZ(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .bcd_in(cnt10), .freeze(1'b0),
        .seg(seg_c), .an(an_c), .frame_done(fd_c)
    );

    bcd_scan_display #(.DIGITS(3), .PRESCALE(2), .BLANK_LZ(1)) dut_d (
        .clk(clk), .rst_n(rst_n), .bcd_in(bcd12), .freeze(frz),
        .seg(seg_d), .an(an_d), .frame_done(fd_d)
    );

    // Upstream mod-10 counter feeding the single-digit instance.
    always @(posedge clk) begin
        if (!rst_n) cnt10 <= 4'd0;
        else        cnt10 <= (cnt10 == 4'd9) ? 4'd0 : cnt10 + 4'd1;
    end

    // Reference model update.
    always @(posedge clk) begin
        if (!rst_n) begin
            t    = 0;
            s_ab = 0;
            s_c  = 0;
            s_d  = 0;
        end else begin
            if ((t % 16) == 15 && !frz) s_ab = {16'h0, bcd16};
            s_c = {28'h0, cnt10};
            if ((t % 6) == 5 && !frz) s_d = {20'h0, bcd12};
            t = t + 1;
        end
    end

    function automatic logic [6:0] seg_tbl(input logic [3:0] d);
        logic [6:0] tbl [16];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        return tbl[d];
    endfunction

    function automatic int exp_idx(input int p, input int d, input int tt);
        return (tt / p) % d;
    endfunction

    function automatic logic [31:0] exp_an(input int p, input int d, input int tt);
        return 32'd1 << exp_idx(p, d, tt);
    endfunction

    function automatic logic [31:0] exp_seg(input int p, input int d, input bit bl,
                                            input int tt, input logic [31:0] snap);
        int          i;
        logic [31:0] upper;
        i     = exp_idx(p, d, tt);
        upper = snap >> (4 * i);
        if (bl && i != 0 && upper == 0) return 32'd0;
        return {25'd0, seg_tbl(upper[3:0])};
    endfunction

    function automatic logic [31:0] exp_fd(input int p, input int d, input int tt);
        return {31'd0, (tt > 0) && ((tt % (p * d)) == 0)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s t=%0d: got %0h expected %0h", tag, t, obs, expv);
        end
    endtask

    task automatic check_all();
        check("an_a",  {28'd0, an_a}, exp_an(4, 4, t));
        check("seg_a", {25'd0, seg_a}, exp_seg(4, 4, 1'b1, t, s_ab));
        check("fd_a",  {31'd0, fd_a}, exp_fd(4, 4, t));
        check("an_b",  {28'd0, an_b}, exp_an(4, 4, t));
        check("seg_b", {25'd0, seg_b}, exp_seg(4, 4, 1'b0, t, s_ab));
        check("fd_b",  {31'd0, fd_b}, exp_fd(4, 4, t));
        check("an_c",  {31'd0, an_c}, exp_an(1, 1, t));
        check("seg_c", {25'd0, seg_c}, exp_seg(1, 1, 1'b1, t, s_c));
        check("fd_c",  {31'd0, fd_c}, exp_fd(1, 1, t));
        check("an_d",  {29'd0, an_d}, exp_an(2, 3, t));
        check("seg_d", {25'd0, seg_d}, exp_seg(2, 3, 1'b1, t, s_d));
        check("fd_d",  {31'd0, fd_d}, exp_fd(2, 3, t));
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            check_all();
        end
    endtask

    // Advance (at most one frame) until the 16-cycle frame position equals k.
    task automatic to_phase(input int k);
        for (int n = 0; n < 16 && (t % 16) != k; n++) cyc(1);
    endtask

    initial begin
        logic [15:0] r16;
        logic [11:0] r12;
        int          k;

        rst_n = 1'b0;
        bcd16 = 16'h1234;
        bcd12 = 12'h000;
        frz   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check("rst_an", {28'd0, an_a}, 32'h1);
        check("rst_seg", {25'd0, seg_a}, 32'h3F);
        check("rst_fd", {31'd0, fd_a}, 32'h0);
        rst_n = 1'b1;

        // Frame 0 shows the reset snapshot; frame 1 shows 1234
        cyc(16);
        check("f1_seg0", {25'd0, seg_a}, 32'h66);
        check("f1_fd16", {31'd0, fd_a}, 32'h1);
        cyc(4);
        check("f1_seg1", {25'd0, seg_a}, 32'h4F);
        cyc(12);
        check("f2_fd32", {31'd0, fd_a}, 32'h1);

        // Leading-zero blanking
        bcd16 = 16'h0050;
        bcd12 = 12'h050;
        cyc(16);
        to_phase(4);
        check("lz_a1", {25'd0, seg_a}, 32'h6D);
        to_phase(8);
        check("lz_a2", {25'd0, seg_a}, 32'h00);
        check("lz_b2", {25'd0, seg_b}, 32'h3F);

        // Invalid code counts as nonzero
        bcd16 = 16'h00A7;
        bcd12 = 12'h0A7;
        cyc(20);
        to_phase(4);
        check("inv_d1", {25'd0, seg_a}, 32'h40);
        to_phase(8);
        check("inv_d2", {25'd0, seg_a}, 32'h00);

        // Snapshot coherence: mid-frame change is not visible until next frame
        bcd16 = 16'h1111;
        cyc(1);
        to_phase(0);
        to_phase(6);
        bcd16 = 16'h2222;
        to_phase(12);
        check("coh_old", {25'd0, seg_a}, 32'h06);
        to_phase(0);
        check("coh_new", {25'd0, seg_a}, 32'h5B);

        // Freeze held across a boundary keeps the old snapshot
        bcd16 = 16'h1111;
        cyc(1);
        to_phase(0);
        frz   = 1'b1;
        bcd16 = 16'h2222;
        cyc(20);
        to_phase(0);
        check("frz_hold", {25'd0, seg_a}, 32'h06);
        frz = 1'b0;

        // Mid-frame reset at idx=2, cnt=1
        cyc(3);
        to_phase(9);
        rst_n = 1'b0;
        cyc(1);
        check("mrst_an", {28'd0, an_a}, 32'h1);
        check("mrst_seg", {25'd0, seg_a}, 32'h3F);
        check("mrst_fd", {31'd0, fd_a}, 32'h0);
        rst_n = 1'b1;
        cyc(3);
        check("mrst_dwell", {28'd0, an_a}, 32'h1);
        cyc(1);
        check("mrst_next", {28'd0, an_a}, 32'h2);

        // Randomised run with occasional freeze and reset
        repeat (800) begin
            for (int i = 0; i < 4; i++) r16[4*i +: 4] = 4'($urandom_range(0, 11));
            for (int i = 0; i < 3; i++) r12[4*i +: 4] = 4'($urandom_range(0, 11));
            k = $urandom_range(0, 4);
            for (int i = 0; i < 4; i++) if (i >= 4 - k) r16[4*i +: 4] = 4'd0;
            for (int i = 0; i < 3; i++) if (i >= 3 - k) r12[4*i +: 4] = 4'd0;
            if ($urandom_range(0, 3) != 0) bcd16 = r16;
            if ($urandom_range(0, 3) != 0) bcd12 = r12;
            frz   = ($urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            cyc(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Time-multiplexed seven-segment display driver that consumes the 4-bit BCD outputs of the cascaded mod-10 synchronous counters. It snapshots all digit values once per frame, scans one digit at a time with a programmable dwell, decodes BCD to segments, and blanks leading zeros. It sits directly downstream of the counter chain and drives the board's common-cathode digit/segment pins.

## Interface
- `DIGITS`, default 4: number of BCD digits scanned (1..8).
- `PRESCALE`, default 4: clk cycles each digit stays selected (>=1).
- `BLANK_LZ`, default 1: 1 blanks leading zeros; 0 shows all digits.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `bcd_in`  in  4*DIGITS  digit i at `bcd_in[4i+3:4i]`; digit 0 is least significant.
- `freeze`  in  1  1 inhibits the frame-boundary snapshot.
- `seg`  out  7  active-high segments, `seg[0]`=a … `seg[6]`=g.
- `an`  out  DIGITS  one-hot, active-high digit select.
- `frame_done`  out  1  one-cycle pulse on the first cycle of each new frame.

## Operation
- Registers:
  - `cnt`: dwell counter, 0..PRESCALE-1.
  - `idx`: scan index, 0..DIGITS-1.
  - `shadow`: 4*DIGITS snapshot.
  - `frame_done` flag.
- Dwell counter:
  - Increments every cycle.
  - At `cnt==PRESCALE-1`, `cnt` wraps to 0 and `idx` advances.
  - `idx` wraps from DIGITS-1 to 0.
- Frame boundary (`cnt==PRESCALE-1 && idx==DIGITS-1`):
  - `shadow <= bcd_in` unless `freeze==1`; with `freeze==1`, `shadow` holds.
  - `frame_done <= 1` next cycle; otherwise `frame_done <= 0`.
- `an` and `seg` are combinational decodes of `idx` and `shadow`:
  - No added latency.
  - `an = 1 << idx`.
- BCD decode of the selected nibble:
  - 0→7'h3F, 1→06, 2→5B, 3→4F, 4→66.
  - 5→6D, 6→7D, 7→07, 8→7F, 9→6F.
  - 10..15 (invalid) → 7'h40 (dash, segment g only).
- Leading-zero blanking (BLANK_LZ=1):
  - Digit i is blank (`seg`=0, `an` still asserted) when it and every more-significant digit in `shadow` are 0.
  - Digit 0 is never blanked.
  - Invalid codes count as nonzero.
- DIGITS=1:
  - `idx` stays 0.
  - A frame boundary occurs every PRESCALE cycles.
- PRESCALE=1: `idx` advances every cycle.

## Timing
- Reset (edge with `rst_n==0`):
  - `cnt=0`, `idx=0`, `shadow=0`, `frame_done=0`.
  - Hence `an`=…0001 and `seg`=7'h3F ("0" on digit 0; with BLANK_LZ, higher digits would be blank).
- Reset has priority over every other event, including a coincident frame boundary; mid-frame reset restarts the scan at digit 0 on the next edge.
- `freeze` is sampled only on the frame-boundary edge; it has no effect elsewhere.
- First snapshot after reset release:
  - Taken at cycle PRESCALE*DIGITS-1 after release (the end of frame 0).
  - New data is visible from cycle PRESCALE*DIGITS.
- Displayed values therefore lag `bcd_in` by 1..PRESCALE*DIGITS cycles.
- Every digit of one frame comes from the same snapshot; there is no mid-frame tearing.
- `frame_done` is high exactly one cycle per frame, on the cycle `idx` returns to 0 with `cnt==0`. It is never high in two consecutive cycles unless PRESCALE*DIGITS==1.

## Test plan
- Reset then scan:
  - Stimulus: DIGITS=4, PRESCALE=4, `bcd_in`=16'h1234, `rst_n` low 2 cycles.
  - Frame 0: `an`=0001 with `seg`=3F, digits 1..3 blank.
  - Frame 1: `an` 0001/0010/0100/1000, 4 cycles each, `seg` 66/4F/5B/06.
  - `frame_done` pulses at cycles 16 and 32 after release.
- Leading-zero blanking:
  - `bcd_in`=16'h0050: frame shows `seg` 3F, 6D, 00, 00.
  - Same input with BLANK_LZ=0: `seg` 3F, 6D, 3F, 3F.
- Invalid code: `bcd_in`=16'h00A7 → digit 0 `seg`=07, digit 1 `seg`=40, digits 2..3 blank.
- Snapshot coherence and freeze:
  - Change `bcd_in` 16'h1111→16'h2222 mid-frame: the current frame stays all 06; the next frame shows 5B.
  - With `freeze`=1 held across a boundary, the display stays 06.
- Mid-operation reset:
  - Assert `rst_n`=0 one cycle at `idx`=2, `cnt`=1.
  - Next edge: `an`=0001, `seg`=3F, `frame_done`=0.
  - The scan resumes from digit 0 with a full 4-cycle dwell.
- Counter integration:
  - Drive `bcd_in[3:0]` from the mod-10 counter (upper digits 0), PRESCALE=1, DIGITS=1.
  - `seg` follows the count sequence 3F,06,5B,…,6F,3F, one frame late.
